// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural vectors, the NOP encoding and the
// fetch-entry record passed from instruction fetch to decode.
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
    localparam logic [31:0] EXCP_VECTOR  = 32'hbfc00380;
    localparam logic [31:0] NOP_INST     = 32'h00000000;

    // One fetched instruction with its PC and an address-error flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                                input logic [31:0] inst,
                                                input logic        adel);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        e.adel = adel;
        return e;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with a synchronous clear. Used by the fetch stage
// both as the in-flight PC tag queue and as the decode-side output buffer.
// DEPTH must be a power of two so the pointers wrap naturally; full/empty
// come from an occupancy count one bit wider than the pointers.
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops every entry at once.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage sitting right after the PC register.
// Issues requests on the SRAM-like instruction port, tags each accepted
// request with its PC, buffers returned instructions and hands them to
// decode over a valid/ready handshake. A redirect (flush) empties the
// buffer and marks every response still owed by memory for dropping.
// In-flight requests plus buffered entries never exceed DEPTH, so neither
// queue can overflow.
// Optional build macro: IF_FETCH_ADEL_CHECK_EN -- when defined, a
// misaligned PC is not sent to memory; instead an AdEL-flagged entry is
// queued for decode once the pipe in front of it has drained.
module if_fetch
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_i,
    output logic        pc_adv,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready,
    output logic        id_excp_adel
);

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   budget_used;
    logic             has_room;
    logic             misaligned;
    logic             adel_push;
    logic             accept;
    logic             resp_keep;

    logic [31:0]      tag_pc;
    logic [CNT_W-1:0] tag_count;
    logic             tag_empty;
    logic             tag_full;

    fetch_entry_t     out_push_data;
    fetch_entry_t     out_head;
    logic             out_push;
    logic             out_pop;
    logic             out_empty;
    logic             out_full;

    logic             unused_bits;

    // Issue budget counts both owed responses and buffered entries.
    assign budget_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign has_room    = (budget_used < (CNT_W + 1)'(DEPTH));

`ifdef IF_FETCH_ADEL_CHECK_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
    // The fault entry waits until older requests have returned so that it
    // reaches decode behind them, in program order.
    assign adel_push  = resetn && !flush && misaligned &&
                        (inflight == '0) && (fifo_count < CNT_W'(DEPTH));
    assign id_excp_adel = id_valid && out_head.adel;
`else
    assign misaligned   = 1'b0;
    assign adel_push    = 1'b0;
    assign id_excp_adel = 1'b0;
`endif

    assign inst_req  = resetn && !flush && !misaligned && has_room;
    assign inst_addr = pc_i;
    assign accept    = inst_req && inst_addr_ok;
    assign pc_adv    = accept || adel_push;

    // A response is kept only when nothing is owed to an earlier redirect
    // and no redirect is happening right now.
    assign resp_keep = inst_data_ok && !flush && (cancel_cnt == '0);

    assign out_push      = resp_keep || adel_push;
    assign out_push_data = adel_push ? make_entry(pc_i, NOP_INST, 1'b1)
                                     : make_entry(tag_pc, inst_rdata, 1'b0);
    assign out_pop       = id_valid && id_ready && !flush;

    assign id_valid = !out_empty;
    assign id_pc    = out_head.pc;
    assign id_inst  = out_head.inst;

    assign unused_bits = ^{tag_count, tag_empty, tag_full, out_full, out_head.adel};

    // PC tags of accepted requests, consumed in order as responses return.
    // A flush does not touch it: cancelled responses still pop their tag.
    if_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_q (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (1'b0),
        .push      (accept),
        .push_data (pc_i),
        .pop       (inst_data_ok),
        .head      (tag_pc),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // Decode-side buffer; registered, so data seen at t is visible at t+1.
    if_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_out_q (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (out_push),
        .push_data (out_push_data),
        .pop       (out_pop),
        .head      (out_head),
        .count     (fifo_count),
        .empty     (out_empty),
        .full      (out_full)
    );

    // Track owed responses and how many of them a redirect has cancelled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inflight   <= '0;
            cancel_cnt <= '0;
        end else begin
            case ({accept, inst_data_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (flush) begin
                cancel_cnt <= inflight - CNT_W'(inst_data_ok);
            end else if (inst_data_ok && (cancel_cnt != '0)) begin
                cancel_cnt <= cancel_cnt - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // Memory must never return data nobody asked for.
    always_ff @(posedge clk) begin
        if (resetn && inst_data_ok) begin
            assert (inflight != '0)
                else $error("if_fetch: inst_data_ok with no request in flight");
        end
    end
`endif

endmodule
